// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use detect plus per-register pending-write scoreboard for long-latency units.
// Latency: stall/bubble are combinational from ID; scoreboard sets/clears land next cycle (HAZARD_SB_WB_BYPASS_EN: writeback releases same cycle).
// Backpressure: any hazard holds PC and IF/ID and injects a bubble into ID/EX; optional macro HAZARD_SB_WB_BYPASS_EN.
module hazard_scoreboard #(
  parameter int NUM_SRC  = 3,
  parameter int NUM_REGS = 32,
  parameter int RA_W     = 5,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [NUM_SRC*RA_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]      id_rs_used,
  input  logic [RA_W-1:0]         id_rd,
  input  logic                    id_reg_write,
  input  logic                    id_is_long,
  input  logic                    idex_mem_read,
  input  logic [RA_W-1:0]         idex_rd,
  input  logic                    long_busy,
  input  logic                    long_wb_valid,
  input  logic [RA_W-1:0]         long_wb_rd,
  input  logic                    ex_kill,
  input  logic [RA_W-1:0]         ex_kill_rd,
  input  logic                    ex_kill_long,
  output logic                    stall_pc,
  output logic                    stall_ifid,
  output logic                    bubble_idex,
  output logic [NUM_REGS-1:0]     pending,
  output logic [CNT_W-1:0]        stall_cycles
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] pend_view, wb_onehot;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
  logic [NUM_SRC-1:0]  src_hit, src_lu;
  logic                load_use, waw, struct_haz, stall, issue;

  // Look up a register in a pending vector; x0 and out-of-range addresses are never pending.
  function automatic logic view_bit(input logic [NUM_REGS-1:0] vec, input logic [RA_W-1:0] a);
    logic hit;
    hit = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (a == RA_W'(r)) hit = vec[r];
    end
    return hit;
  endfunction

  // One-hot of the retiring register, with x0 and out-of-range addresses dropped.
  always_comb begin
    wb_onehot = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (long_wb_valid && (long_wb_rd == RA_W'(r))) wb_onehot[r] = 1'b1;
    end
  end

`ifdef HAZARD_SB_WB_BYPASS_EN
  // A retiring result is forwarded, so its register stops blocking in the writeback cycle.
  assign pend_view = pending_q & ~wb_onehot;
`else
  // Dependents wait until the cleared bit is visible in the register.
  assign pend_view = pending_q;
`endif

  // Hazard detection over all source operands plus WAW and structural checks.
  always_comb begin
    src_hit = '0;
    src_lu  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_hit[i] = id_valid & id_rs_used[i] & (id_rs[i*RA_W +: RA_W] != '0) &
                   view_bit(pend_view, id_rs[i*RA_W +: RA_W]);
      src_lu[i]  = id_rs_used[i] & (id_rs[i*RA_W +: RA_W] == idex_rd);
    end
    load_use   = id_valid & idex_mem_read & (idex_rd != '0) & (|src_lu);
    waw        = id_valid & id_reg_write & (id_rd != '0) & view_bit(pend_view, id_rd);
    struct_haz = id_valid & id_is_long & long_busy;
    stall      = load_use | (|src_hit) | waw | struct_haz;
    issue      = id_valid & ~stall;
  end

  assign stall_pc     = stall;
  assign stall_ifid   = stall;
  assign bubble_idex  = stall;
  assign pending      = pending_q;
  assign stall_cycles = stall_cycles_q;

  // Scoreboard update: writeback clear, then kill clear, then issue set (a new producer wins).
  always_comb begin
    pending_d = pending_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (wb_onehot[r]) pending_d[r] = 1'b0;
      if (ex_kill && ex_kill_long && (ex_kill_rd == RA_W'(r))) pending_d[r] = 1'b0;
      if (issue && id_is_long && id_reg_write && (id_rd == RA_W'(r))) pending_d[r] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  // State registers with immediate reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      pending_q      <= pending_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic against a behavioural scoreboard model.
// Latency: hazard outputs checked combinationally; scoreboard and counter checked 1 ns after each edge.
// Backpressure: the model predicts stall each cycle; counter instance uses a 4-bit width to reach saturation.
module tb_hazard_scoreboard;
  localparam int NSRC  = 3;
  localparam int NREGS = 32;
  localparam int RAW   = 5;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef HAZARD_SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 id_valid, id_reg_write, id_is_long;
  logic [NSRC*RAW-1:0]  id_rs;
  logic [NSRC-1:0]      id_rs_used;
  logic [RAW-1:0]       id_rd, idex_rd, long_wb_rd, ex_kill_rd;
  logic                 idex_mem_read, long_busy, long_wb_valid, ex_kill, ex_kill_long;
  logic                 stall_pc, stall_ifid, bubble_idex;
  logic [NREGS-1:0]     pending;
  logic [CW-1:0]        stall_cycles;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: one flag per architectural register and a plain integer counter.
  bit mp[NREGS];
  int mcnt;

  hazard_scoreboard #(.NUM_SRC(NSRC), .NUM_REGS(NREGS), .RA_W(RAW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_long(id_is_long),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .long_busy(long_busy),
    .long_wb_valid(long_wb_valid), .long_wb_rd(long_wb_rd), .ex_kill(ex_kill),
    .ex_kill_rd(ex_kill_rd), .ex_kill_long(ex_kill_long), .stall_pc(stall_pc),
    .stall_ifid(stall_ifid), .bubble_idex(bubble_idex), .pending(pending),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic bit blocked(input int r);
    if (r == 0 || r >= NREGS) return 1'b0;
    if (BYP && long_wb_valid && int'(long_wb_rd) == r) return 1'b0;
    return mp[r];
  endfunction

  function automatic bit model_stall();
    bit s;
    int rs;
    s = 1'b0;
    if (!id_valid) return 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      rs = int'(id_rs[i*RAW +: RAW]);
      if (id_rs_used[i] && blocked(rs)) s = 1'b1;
      if (idex_mem_read && idex_rd != 0 && id_rs_used[i] && rs == int'(idex_rd)) s = 1'b1;
    end
    if (id_reg_write && blocked(int'(id_rd))) s = 1'b1;
    if (id_is_long && long_busy) s = 1'b1;
    return s;
  endfunction

  function automatic logic [NREGS-1:0] exp_pend();
    logic [NREGS-1:0] v;
    for (int r = 0; r < NREGS; r++) v[r] = mp[r];
    return v;
  endfunction

  function automatic logic [RAW*NSRC-1:0] srcs(input int a, input int b, input int c);
    return {RAW'(c), RAW'(b), RAW'(a)};
  endfunction

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_reg_write = 0; id_is_long = 0;
    idex_mem_read = 0; idex_rd = '0; long_busy = 0; long_wb_valid = 0; long_wb_rd = '0;
    ex_kill = 0; ex_kill_rd = '0; ex_kill_long = 0;
  endtask

  // Advance one clock, updating the model from the inputs presented during the cycle.
  task automatic tick();
    bit s;
    bit nxt[NREGS];
    s = model_stall();
    nxt = mp;
    if (long_wb_valid && int'(long_wb_rd) < NREGS) nxt[int'(long_wb_rd)] = 1'b0;
    if (ex_kill && ex_kill_long && int'(ex_kill_rd) < NREGS) nxt[int'(ex_kill_rd)] = 1'b0;
    if (id_valid && !s && id_is_long && id_reg_write && int'(id_rd) < NREGS) nxt[int'(id_rd)] = 1'b1;
    nxt[0] = 1'b0;
    if (s && mcnt < CMAX) mcnt++;
    @(posedge clk);
    mp = nxt;
    #1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) mp[r] = 1'b0;
    mcnt = 0;
  endtask

  task automatic test_reset();
    idle();
    #1 reset = 1'b1;
    model_reset();
    #1;
    n_chk++; if (pending !== '0) $display("FAIL rst_pending got=%h exp=0", pending); else n_pass++;
    n_chk++; if (stall_cycles !== '0) $display("FAIL rst_count got=%0d exp=0", stall_cycles); else n_pass++;
    n_chk++; if ({stall_pc, stall_ifid, bubble_idex} !== 3'b000) $display("FAIL rst_stall got=%b exp=000", {stall_pc, stall_ifid, bubble_idex}); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    idle();
    id_valid = 1; idex_mem_read = 1; idex_rd = 5; id_rs = srcs(5, 0, 0); id_rs_used = 3'b001;
    #1;
    n_chk++; if ({stall_pc, stall_ifid, bubble_idex} !== 3'b111) $display("FAIL lu_stall got=%b exp=111", {stall_pc, stall_ifid, bubble_idex}); else n_pass++;
    tick();
    n_chk++; if (stall_cycles !== CW'(mcnt)) $display("FAIL lu_count got=%0d exp=%0d", stall_cycles, mcnt); else n_pass++;
    idex_mem_read = 0; #1;
    n_chk++; if (stall_pc !== 1'b0) $display("FAIL lu_release got=%b exp=0", stall_pc); else n_pass++;
    tick();
    idex_mem_read = 1; id_rs_used = 3'b000; #1;
    n_chk++; if (stall_pc !== 1'b0) $display("FAIL lu_unused got=%b exp=0", stall_pc); else n_pass++;
    id_rs = srcs(0, 0, 5); id_rs_used = 3'b100; #1;
    n_chk++; if (bubble_idex !== 1'b1) $display("FAIL lu_src2 got=%b exp=1", bubble_idex); else n_pass++;
    idex_rd = 0; id_rs = srcs(0, 0, 0); #1;
    n_chk++; if (stall_pc !== 1'b0) $display("FAIL lu_x0 got=%b exp=0", stall_pc); else n_pass++;
    tick();
  endtask

  task automatic test_long_raw();
    idle();
    id_valid = 1; id_is_long = 1; id_reg_write = 1; id_rd = 7; #1;
    n_chk++; if (stall_pc !== 1'b0) $display("FAIL raw_issue got=%b exp=0", stall_pc); else n_pass++;
    tick();
    n_chk++; if (pending[7] !== 1'b1) $display("FAIL raw_set got=%b exp=1", pending[7]); else n_pass++;
    idle();
    id_valid = 1; id_rs = srcs(0, 7, 0); id_rs_used = 3'b010; long_busy = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (stall_pc !== 1'b1) $display("FAIL raw_hold%0d got=%b exp=1", k, stall_pc); else n_pass++;
      tick();
    end
    long_wb_valid = 1; long_wb_rd = 7; #1;
    n_chk++; if (stall_pc !== !BYP) $display("FAIL raw_wb_cycle got=%b exp=%b", stall_pc, !BYP); else n_pass++;
    tick();
    n_chk++; if (pending[7] !== 1'b0) $display("FAIL raw_clear got=%b exp=0", pending[7]); else n_pass++;
    long_wb_valid = 0; #1;
    n_chk++; if (stall_pc !== 1'b0) $display("FAIL raw_after got=%b exp=0", stall_pc); else n_pass++;
    tick();
  endtask

  task automatic test_waw_x0();
    idle();
    id_valid = 1; id_is_long = 1; id_reg_write = 1; id_rd = 9;
    tick();
    id_is_long = 0; #1;
    n_chk++; if (stall_pc !== 1'b1) $display("FAIL waw_stall got=%b exp=1", stall_pc); else n_pass++;
    tick();
    long_wb_valid = 1; long_wb_rd = 9; #1;
    n_chk++; if (stall_pc !== !BYP) $display("FAIL waw_wb_cycle got=%b exp=%b", stall_pc, !BYP); else n_pass++;
    tick();
    long_wb_valid = 0; #1;
    n_chk++; if (stall_pc !== 1'b0) $display("FAIL waw_release got=%b exp=0", stall_pc); else n_pass++;
    tick();
    id_is_long = 1; id_rd = 0; #1;
    n_chk++; if (stall_pc !== 1'b0) $display("FAIL x0_issue got=%b exp=0", stall_pc); else n_pass++;
    tick();
    n_chk++; if (pending !== '0) $display("FAIL x0_pending got=%h exp=0", pending); else n_pass++;
  endtask

  task automatic test_set_clear();
    idle();
    long_wb_valid = 1; long_wb_rd = 3; ex_kill = 1; ex_kill_long = 1; ex_kill_rd = 3;
    id_valid = 1; id_is_long = 1; id_reg_write = 1; id_rd = 3;
    tick();
    n_chk++; if (pending[3] !== 1'b1) $display("FAIL setclr_win got=%b exp=1", pending[3]); else n_pass++;
    idle();
    long_wb_valid = 1; long_wb_rd = 3;
    tick();
    n_chk++; if (pending[3] !== 1'b0) $display("FAIL setclr_clear got=%b exp=0", pending[3]); else n_pass++;
  endtask

  task automatic test_kill();
    idle();
    id_valid = 1; id_is_long = 1; id_reg_write = 1; id_rd = 12;
    tick();
    id_rd = 13;
    tick();
    n_chk++; if (pending !== 32'h0000_3000) $display("FAIL kill_setup got=%h exp=00003000", pending); else n_pass++;
    idle();
    ex_kill = 1; ex_kill_long = 1; ex_kill_rd = 12;
    tick();
    n_chk++; if (pending[12] !== 1'b0) $display("FAIL kill_clear got=%b exp=0", pending[12]); else n_pass++;
    ex_kill_long = 0; ex_kill_rd = 13;
    tick();
    n_chk++; if (pending[13] !== 1'b1) $display("FAIL kill_notlong got=%b exp=1", pending[13]); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    idle();
    id_valid = 1; id_rs = srcs(13, 0, 0); id_rs_used = 3'b001; #1;
    n_chk++; if (stall_pc !== 1'b1) $display("FAIL rms_stall got=%b exp=1", stall_pc); else n_pass++;
    tick();
    n_chk++; if (stall_cycles === '0) $display("FAIL rms_count_nonzero got=%0d exp=nonzero", stall_cycles); else n_pass++;
    reset = 1'b1;
    model_reset();
    #1;
    n_chk++; if (pending !== '0) $display("FAIL rms_pending got=%h exp=0", pending); else n_pass++;
    n_chk++; if (stall_cycles !== '0) $display("FAIL rms_count got=%0d exp=0", stall_cycles); else n_pass++;
    n_chk++; if (stall_pc !== 1'b0) $display("FAIL rms_release got=%b exp=0", stall_pc); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_counter();
    idle();
    id_valid = 1; id_is_long = 1; long_busy = 1;
    for (int k = 0; k < 20; k++) tick();
    n_chk++; if (stall_cycles !== 4'hF) $display("FAIL cnt_sat got=%0d exp=15", stall_cycles); else n_pass++;
    tick();
    n_chk++; if (stall_cycles !== 4'hF) $display("FAIL cnt_nowrap got=%0d exp=15", stall_cycles); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int k = 0; k < 400; k++) begin
      id_valid      = ($urandom_range(3) != 0);
      id_rs         = srcs($urandom_range(7), $urandom_range(7), $urandom_range(7));
      id_rs_used    = 3'($urandom_range(7));
      id_rd         = 5'($urandom_range(7));
      id_reg_write  = ($urandom_range(3) != 0);
      id_is_long    = ($urandom_range(2) == 0);
      idex_mem_read = ($urandom_range(3) == 0);
      idex_rd       = 5'($urandom_range(7));
      long_busy     = ($urandom_range(3) == 0);
      long_wb_valid = ($urandom_range(2) == 0);
      long_wb_rd    = 5'($urandom_range(7));
      ex_kill       = ($urandom_range(7) == 0);
      ex_kill_long  = ($urandom_range(1) == 0);
      ex_kill_rd    = 5'($urandom_range(7));
      #1;
      n_chk++;
      if ({stall_pc, stall_ifid, bubble_idex} !== {3{model_stall()}}) begin
        if (errs < 10) $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", k, {stall_pc, stall_ifid, bubble_idex}, {3{model_stall()}});
        errs++;
      end else n_pass++;
      tick();
      n_chk++;
      if (pending !== exp_pend()) begin
        if (errs < 10) $display("FAIL rnd_pending cyc=%0d got=%h exp=%h", k, pending, exp_pend());
        errs++;
      end else n_pass++;
      n_chk++;
      if (stall_cycles !== CW'(mcnt)) begin
        if (errs < 10) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", k, stall_cycles, mcnt);
        errs++;
      end else n_pass++;
    end
    idle();
  endtask

  initial begin
    model_reset();
    idle();
    test_reset();
    test_load_use();
    test_long_raw();
    test_waw_x0();
    test_set_clear();
    test_kill();
    test_reset_mid_stall();
    test_counter();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
